// File: rtl/qsys_pio_pkg.sv
// Shared definitions for the key input PIO: register map and edge-type encodings.
package qsys_pio_pkg;

  // Word addresses of the slave register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Which transition of the debounced level is captured
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Reduce a bit's rise/fall pulses to the edge event selected by edge_type
  function automatic logic edge_event(input int edge_type, input logic rise, input logic fall);
    case (edge_type)
      EDGE_RISING:  edge_event = rise;
      EDGE_FALLING: edge_event = fall;
      default:      edge_event = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: 2-FF synchroniser, hold-time debounce counter, stable level,
// and single-cycle rise/fall pulses asserted in the cycle the stable level flips.
module pio_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // New level is accepted once it has differed from stable for DEBOUNCE_CYCLES cycles
  always_comb begin
    sync1_d  = in_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    accept   = (sync2_q != stable_q) && (cnt_q == CNT_LAST);
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, stable level and counter state; reset discards any partial debounce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = accept & sync2_q;
  assign fall   = accept & ~sync2_q;

endmodule

// File: rtl/qsys_key_pio.sv
// Avalon-MM input PIO for push-buttons/switches: debounced data register,
// per-bit edge capture (write-1-to-clear), interrupt mask and level irq.
module qsys_key_pio
  import qsys_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (IN_RESET_VALUE[i])
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .in_raw(in_port[i]),
      .stable(data_stable[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

  // Upper write-data bits beyond WIDTH carry no meaning
  assign unused_wdata = ^writedata;

  // Register-file updates: mask load, edge capture with set taking priority over clear
  always_comb begin
    wr_en      = chipselect && !write_n;
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en && (address == ADDR_IRQMASK)) irq_mask_d = writedata[WIDTH-1:0];
    if (wr_en && (address == ADDR_EDGECAP)) clr = writedata[WIDTH-1:0];
    for (int i = 0; i < WIDTH; i++) edge_ev[i] = edge_event(EDGE_TYPE, rise[i], fall[i]);
    edge_capture_d = (edge_capture_q & ~clr) | edge_ev;
  end

  // Mask and capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  // Zero-latency read mux, independent of chipselect, zero-extended
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = data_stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_qsys_key_pio.sv
// Bench for qsys_key_pio: falling-edge instance plus an any-edge instance on a shared bus.
module tb_qsys_key_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [3:0]  in_port2;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic        irq;
  logic        irq2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          kind;   // 0: dut read, 1: dut irq, 2: any-edge dut read
    logic [1:0]  addr;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  always #10 clk = ~clk;

  qsys_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  qsys_key_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port2),
    .readdata(readdata2), .irq(irq2)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input string tag, input logic [1:0] a, input logic [31:0] e);
    sb_q.push_back('{tag: tag, kind: 0, addr: a, exp: e});
  endtask

  task automatic exp_irq(input string tag, input logic e);
    sb_q.push_back('{tag: tag, kind: 1, addr: 2'd0, exp: {31'd0, e}});
  endtask

  task automatic exp_rd2(input string tag, input logic [1:0] a, input logic [31:0] e);
    sb_q.push_back('{tag: tag, kind: 2, addr: a, exp: e});
  endtask

  // Compare every pending expectation against the live outputs
  task automatic drain();
    sb_item_t it;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      address = it.addr;
      #1;
      case (it.kind)
        0:       obs = readdata;
        1:       obs = {31'd0, irq};
        default: obs = readdata2;
      endcase
      check_eq(it.tag, obs, it.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    in_port2   = 4'hF;
    step(3);
    reset = 1'b0;
    step(1);

    exp_rd("rst_data", 2'd0, 32'h0000_000F);
    exp_rd("rst_rsvd", 2'd1, 32'h0);
    exp_rd("rst_mask", 2'd2, 32'h0);
    exp_rd("rst_edge", 2'd3, 32'h0);
    exp_irq("rst_irq", 1'b0);
    drain();

    // Press key 0 and hold: stable flips on the 6th edge after the change
    in_port[0] = 1'b0;
    step(5);
    exp_rd("press0_early", 2'd0, 32'hF);
    exp_rd("press0_edge_early", 2'd3, 32'h0);
    drain();
    step(1);
    exp_rd("press0_data", 2'd0, 32'hE);
    exp_rd("press0_edge", 2'd3, 32'h1);
    exp_irq("press0_irq_masked", 1'b0);
    drain();

    bus_write(2'd2, 32'h1);
    exp_rd("mask_rd", 2'd2, 32'h1);
    exp_irq("mask_irq_on", 1'b1);
    drain();

    bus_write(2'd3, 32'h1);
    exp_rd("clr0_edge", 2'd3, 32'h0);
    exp_irq("clr0_irq_off", 1'b0);
    drain();

    // Release key 0: falling-only capture ignores the rising edge
    in_port[0] = 1'b1;
    step(8);
    exp_rd("rel0_data", 2'd0, 32'hF);
    exp_rd("rel0_edge", 2'd3, 32'h0);
    drain();

    // 3-cycle glitch on key 1 is filtered
    in_port[1] = 1'b0;
    step(3);
    in_port[1] = 1'b1;
    step(8);
    exp_rd("glitch1_data", 2'd0, 32'hF);
    exp_rd("glitch1_edge", 2'd3, 32'h0);
    drain();

    // Writes to data and reserved words have no effect
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    exp_rd("ro_data", 2'd0, 32'hF);
    exp_rd("ro_rsvd", 2'd1, 32'h0);
    drain();

    // Falling edge on key 2 coincides with a clear of bit 2: set wins
    in_port[2] = 1'b0;
    step(5);
    bus_write(2'd3, 32'h4);
    exp_rd("setwin_edge", 2'd3, 32'h4);
    exp_rd("setwin_data", 2'd0, 32'hB);
    exp_irq("setwin_irq_masked", 1'b0);
    drain();

    bus_write(2'd2, 32'h4);
    exp_irq("mask2_irq_on", 1'b1);
    drain();
    bus_write(2'd2, 32'h0);
    exp_irq("unmask2_irq_off", 1'b0);
    exp_rd("unmask2_edge_kept", 2'd3, 32'h4);
    drain();
    bus_write(2'd3, 32'h4);
    exp_rd("clr2_edge", 2'd3, 32'h0);
    drain();
    in_port[2] = 1'b1;
    step(8);
    exp_rd("rel2_data", 2'd0, 32'hF);
    drain();

    // Reset in the middle of debouncing key 3
    bus_write(2'd2, 32'hF);
    in_port[3] = 1'b0;
    step(4);
    reset = 1'b1;
    step(2);
    exp_rd("midrst_data", 2'd0, 32'hF);
    exp_rd("midrst_mask", 2'd2, 32'h0);
    exp_rd("midrst_edge", 2'd3, 32'h0);
    exp_irq("midrst_irq", 1'b0);
    drain();
    reset = 1'b0;
    step(5);
    exp_rd("post_rst_early", 2'd0, 32'hF);
    exp_rd("post_rst_edge_early", 2'd3, 32'h0);
    drain();
    step(1);
    exp_rd("post_rst_data", 2'd0, 32'h7);
    exp_rd("post_rst_edge", 2'd3, 32'h8);
    exp_irq("post_rst_irq", 1'b0);
    drain();
    in_port[3] = 1'b1;
    step(8);

    // Any-edge instance: press sets bit 0, release keeps it set
    in_port2[0] = 1'b0;
    step(6);
    exp_rd2("any_press_data", 2'd0, 32'hE);
    exp_rd2("any_press_edge", 2'd3, 32'h1);
    drain();
    in_port2[0] = 1'b1;
    step(6);
    exp_rd2("any_rel_data", 2'd0, 32'hF);
    exp_rd2("any_rel_edge", 2'd3, 32'h1);
    drain();
    bus_write(2'd3, 32'h1);
    exp_rd2("any_clr_edge", 2'd3, 32'h0);
    drain();
    in_port2[0] = 1'b0;
    step(6);
    in_port2[0] = 1'b1;
    bus_write(2'd3, 32'h1);
    step(5);
    exp_rd2("any_rise_only_edge", 2'd3, 32'h1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
